// File: rtl/riscv_mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave):
// req/gnt address phase followed by an rvalid read-data phase.
interface riscv_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/riscv_mem_stage.sv
// RV32I memory-access stage: issues load/store bus transactions, aligns and extends
// data, stalls the pipeline while an access is in flight, flags misalign and timeouts.
module riscv_mem_stage #(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_mem_stage_is_load,
    input  logic              i_mem_stage_mem_wr_en,
    input  logic [3:0]        i_mem_stage_byte_sel,
    input  logic [XLEN-1:0]   i_mem_stage_addr,
    input  logic [XLEN-1:0]   i_mem_stage_wdata,
    input  logic [2:0]        i_mem_stage_func3,
    riscv_mem_stage_if.master dmem,
    output logic [XLEN-1:0]   o_mem_stage_load_data,
    output logic              o_mem_stage_stall,
    output logic              o_mem_stage_misalign,
    output logic              o_mem_stage_bus_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    // Access attributes latched at issue so load alignment does not depend on EX/MEM holding.
    typedef struct packed {
        logic       ld;
        logic [1:0] sh;
        logic [2:0] f3;
    } acc_t;

    state_t          state, state_nxt;
    acc_t            acc_q;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      sh;
    logic            access, misaligned, issue, done, abort;
    logic [XLEN-1:0] rd_shifted;

    function automatic logic [XLEN-1:0] ld_extend(input logic [2:0] f3, input logic [XLEN-1:0] r);
        case (f3)
            3'b000:  return {{(XLEN-8){r[7]}}, r[7:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, r[7:0]};
            3'b001:  return {{(XLEN-16){r[15]}}, r[15:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, r[15:0]};
            default: return r;
        endcase
    endfunction

    assign access     = i_mem_stage_is_load | i_mem_stage_mem_wr_en;
    assign sh         = i_mem_stage_addr[1:0];
    assign misaligned = access & ((i_mem_stage_func3[1:0] == 2'b01 & sh[0]) |
                                  (i_mem_stage_func3[1:0] == 2'b10 & sh != 2'b00));
    assign issue      = (state == IDLE) & access & ~misaligned;
    assign done       = (state == REQ & dmem.gnt & ~acc_q.ld) | (state == RSP & dmem.rvalid);
    // A completion landing on the last allowed cycle wins over the timeout.
    assign abort      = (state != IDLE) & ~done & (wait_cnt == CW'(WAIT_MAX));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = REQ;
            REQ: begin
                if (abort || (dmem.gnt && !acc_q.ld)) state_nxt = IDLE;
                else if (dmem.gnt)                    state_nxt = RSP;
            end
            RSP:     if (done || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_mem_stage_stall     = 1'b0;
        o_mem_stage_misalign  = 1'b0;
        o_mem_stage_bus_err   = 1'b0;
        o_mem_stage_load_data = '0;
        rd_shifted            = dmem.rdata >> {acc_q.sh, 3'b000};
        case (state)
            IDLE: begin
                o_mem_stage_stall    = issue;
                o_mem_stage_misalign = misaligned;
            end
            default: begin
                o_mem_stage_stall   = ~done & ~abort;
                o_mem_stage_bus_err = abort;
                if (state == RSP && dmem.rvalid)
                    o_mem_stage_load_data = ld_extend(acc_q.f3, rd_shifted);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)               wait_cnt <= '0;
        else if (state == IDLE)    wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 1'b1;
    end

    // Bus outputs are registered; they hold until gnt (or timeout), then clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            dmem.be    <= '0;
            acc_q      <= '0;
        end else if (issue) begin
            dmem.req   <= 1'b1;
            dmem.we    <= ~i_mem_stage_is_load;
            dmem.addr  <= {i_mem_stage_addr[XLEN-1:2], 2'b00};
            dmem.wdata <= i_mem_stage_wdata << {sh, 3'b000};
            dmem.be    <= 4'(i_mem_stage_byte_sel << sh);
            acc_q      <= '{ld: i_mem_stage_is_load, sh: sh, f3: i_mem_stage_func3};
        end else if (state == REQ && (dmem.gnt || abort)) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            dmem.be    <= '0;
        end
    end
endmodule

// File: tb/tb_riscv_mem_stage.sv
// Self-checking bench for riscv_mem_stage: directed cases plus randomized accesses
// checked against a byte-level reference model of the load/store rules.
module tb_riscv_mem_stage;
    localparam int WM = 8;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_mem_stage_is_load, i_mem_stage_mem_wr_en;
    logic [3:0]  i_mem_stage_byte_sel;
    logic [31:0] i_mem_stage_addr, i_mem_stage_wdata;
    logic [2:0]  i_mem_stage_func3;
    logic [31:0] o_mem_stage_load_data;
    logic        o_mem_stage_stall, o_mem_stage_misalign, o_mem_stage_bus_err;

    int checks = 0;
    int failures = 0;

    riscv_mem_stage_if #(.XLEN(32)) bus ();

    riscv_mem_stage #(.XLEN(32), .WAIT_MAX(WM)) dut (
        .i_clk                 (i_clk),
        .i_rstn                (i_rstn),
        .i_mem_stage_is_load   (i_mem_stage_is_load),
        .i_mem_stage_mem_wr_en (i_mem_stage_mem_wr_en),
        .i_mem_stage_byte_sel  (i_mem_stage_byte_sel),
        .i_mem_stage_addr      (i_mem_stage_addr),
        .i_mem_stage_wdata     (i_mem_stage_wdata),
        .i_mem_stage_func3     (i_mem_stage_func3),
        .dmem                  (bus),
        .o_mem_stage_load_data (o_mem_stage_load_data),
        .o_mem_stage_stall     (o_mem_stage_stall),
        .o_mem_stage_misalign  (o_mem_stage_misalign),
        .o_mem_stage_bus_err   (o_mem_stage_bus_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference load: gather the addressed bytes, then sign-correct if the top bit is set.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int     n  = nbytes(f3);
        int     sh = int'(a % 4);
        longint v  = 0;
        for (int i = 0; i < n; i++)
            v += longint'((rd >> (8 * (sh + i))) & 32'hFF) << (8 * i);
        if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // One access from the issue cycle until stall drops; bench plays the memory slave.
    task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rvd, input string tag);
        int n, sh, c, endc, cyc, g, req_cnt, reqc, stallc, errc, misc, nzc;
        bit mis, abrt, done, stable, rv_real;
        logic [31:0] f_addr, f_wd, lane, exp_wd, ld_obs;
        logic [3:0]  f_be, exp_be;
        logic        f_we;
        n      = nbytes(f3);
        sh     = int'(a % 4);
        mis    = (a % n) != 0;
        c      = ld ? gd + 1 + rvd : gd;
        abrt   = !mis && c > WM;
        endc   = mis ? 0 : (abrt ? WM + 1 : c + 1);
        exp_be = 4'(((1 << n) - 1) << sh);
        lane   = '0;
        exp_wd = '0;
        for (int i = 0; i < 4; i++)
            if (exp_be[i]) begin
                lane[8*i +: 8]   = 8'hFF;
                exp_wd[8*i +: 8] = wd[8*(i-sh) +: 8];
            end
        i_mem_stage_is_load   = ld;
        i_mem_stage_mem_wr_en = !ld;
        i_mem_stage_byte_sel  = 4'((1 << n) - 1);
        i_mem_stage_addr      = a;
        i_mem_stage_wdata     = wd;
        i_mem_stage_func3     = f3;
        cyc = 0; g = -1; req_cnt = 0; reqc = 0; stallc = 0; errc = 0; misc = 0; nzc = 0;
        done = 0; stable = 1; ld_obs = 'x;
        f_addr = '0; f_wd = '0; f_be = '0; f_we = 1'b0;
        while (!done && cyc < 40) begin
            bus.gnt    = bus.req && g < 0 && req_cnt == gd;
            rv_real    = ld && g >= 0 && (cyc - g - 1) == rvd;
            bus.rvalid = rv_real || (g < 0 && $urandom_range(1, 0) == 1);
            bus.rdata  = rv_real ? rd : $urandom;
            #1;
            if (o_mem_stage_stall)    stallc++;
            if (o_mem_stage_bus_err)  errc++;
            if (o_mem_stage_misalign) misc++;
            if (bus.req) begin
                if (reqc == 0) begin
                    f_addr = bus.addr; f_wd = bus.wdata; f_be = bus.be; f_we = bus.we;
                end else if ({bus.addr, bus.wdata, bus.be, bus.we} !== {f_addr, f_wd, f_be, f_we}) begin
                    stable = 0;
                end
                reqc++;
            end
            if (rv_real) ld_obs = o_mem_stage_load_data;
            else if (o_mem_stage_load_data !== 32'h0) nzc++;
            if (bus.gnt) g = cyc;
            if (bus.req) req_cnt++;
            done = !o_mem_stage_stall;
            @(posedge i_clk);
            #2;
            cyc++;
        end
        i_mem_stage_is_load   = 1'b0;
        i_mem_stage_mem_wr_en = 1'b0;
        bus.gnt               = 1'b0;
        bus.rvalid            = 1'b0;
        chk({tag, " stall_cycles"}, stallc, endc);
        chk({tag, " req_cycles"}, reqc, mis ? 0 : ((gd < WM ? gd : WM) + 1));
        chk({tag, " bus_err"}, errc, 32'(abrt));
        chk({tag, " misalign"}, misc, 32'(mis));
        chk({tag, " load_data_idle"}, nzc, 0);
        if (reqc > 0) begin
            chk({tag, " addr"}, f_addr, a - 32'(sh));
            chk({tag, " be"}, 32'(f_be), 32'(exp_be));
            chk({tag, " we"}, 32'(f_we), 32'(!ld));
            chk({tag, " stable"}, 32'(stable), 1);
            if (!ld) chk({tag, " wdata"}, f_wd & lane, exp_wd);
        end
        if (ld && !mis && !abrt) chk({tag, " load_data"}, ld_obs, ref_load(f3, a, rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        i_mem_stage_is_load = 0; i_mem_stage_mem_wr_en = 0; i_mem_stage_byte_sel = 0;
        i_mem_stage_addr = 0; i_mem_stage_wdata = 0; i_mem_stage_func3 = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;

        repeat (2) @(posedge i_clk);
        #2;
        chk("reset req", 32'(bus.req), 0);
        chk("reset we", 32'(bus.we), 0);
        chk("reset addr", bus.addr, 0);
        chk("reset wdata", bus.wdata, 0);
        chk("reset be", 32'(bus.be), 0);
        chk("reset stall", 32'(o_mem_stage_stall), 0);
        chk("reset misalign", 32'(o_mem_stage_misalign), 0);
        chk("reset bus_err", 32'(o_mem_stage_bus_err), 0);
        chk("reset load_data", o_mem_stage_load_data, 0);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #3;
        chk("nop stall", 32'(o_mem_stage_stall), 0);
        chk("nop req", 32'(bus.req), 0);
        @(posedge i_clk);
        #2;

        access(0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, "sw");
        access(0, 3'b000, 32'h103, 32'h000000A5, 0, 3, 0, "sb");
        access(1, 3'b000, 32'h102, 0, 32'h80F01234, 1, 1, "lb");
        access(1, 3'b100, 32'h102, 0, 32'h80F01234, 0, 2, "lbu");
        access(1, 3'b001, 32'h102, 0, 32'h80F01234, 2, 0, "lh");
        access(1, 3'b101, 32'h102, 0, 32'h80F01234, 0, 0, "lhu");
        access(1, 3'b010, 32'h106, 0, 0, 0, 0, "lw_mis");
        access(1, 3'b001, 32'h101, 0, 0, 0, 0, "lh_mis");
        access(1, 3'b010, 32'h200, 0, 32'h12345678, 0, 100, "lw_timeout");
        access(0, 3'b010, 32'h204, 32'hCAFEF00D, 0, 100, 0, "sw_timeout");
        access(0, 3'b001, 32'h206, 32'h0000BEEF, 0, WM, 0, "sh_edge");
        access(1, 3'b010, 32'h208, 0, 32'h0BADF00D, 3, WM - 4, "lw_edge");
        access(1, 3'b010, 32'h20C, 0, 32'h0BADF00D, 3, WM - 3, "lw_over");

        // Reset while waiting for rvalid; a late rvalid afterwards must be ignored.
        i_mem_stage_is_load = 1; i_mem_stage_func3 = 3'b010;
        i_mem_stage_addr = 32'h300; i_mem_stage_byte_sel = 4'hF;
        @(posedge i_clk); #2;
        bus.gnt = 1;
        #1 chk("rst_rsp req", 32'(bus.req), 1);
        @(posedge i_clk); #2;
        bus.gnt = 0;
        #1 chk("rst_rsp stall", 32'(o_mem_stage_stall), 1);
        i_rstn = 0;
        #1 chk("rst_rsp req_low", 32'(bus.req), 0);
        i_mem_stage_is_load = 0;
        @(posedge i_clk); #2;
        i_rstn = 1; bus.rvalid = 1; bus.rdata = 32'hFFFFFFFF;
        #1 chk("late_rvalid stall", 32'(o_mem_stage_stall), 0);
        chk("late_rvalid load_data", o_mem_stage_load_data, 0);
        @(posedge i_clk); #2;
        bus.rvalid = 0;
        #1 chk("late_rvalid req", 32'(bus.req), 0);
        @(posedge i_clk); #2;

        // Reset while a store request is pending drops the request immediately.
        i_mem_stage_mem_wr_en = 1; i_mem_stage_func3 = 3'b010;
        i_mem_stage_addr = 32'h310; i_mem_stage_wdata = 32'h11223344;
        @(posedge i_clk); #2;
        #1 chk("rst_req req", 32'(bus.req), 1);
        i_rstn = 0;
        #1 chk("rst_req req_low", 32'(bus.req), 0);
        chk("rst_req be", 32'(bus.be), 0);
        i_mem_stage_mem_wr_en = 0;
        @(posedge i_clk); #2;
        i_rstn = 1;
        @(posedge i_clk); #2;

        for (int k = 0; k < 24; k++) begin
            bit          ld;
            logic [2:0]  f3;
            ld = $urandom_range(1, 0) == 1;
            f3 = ld ? ld_f3s[$urandom_range(4, 0)] : ld_f3s[$urandom_range(2, 0)];
            access(ld, f3, 32'h1000 + 32'($urandom_range(63, 0)), $urandom, $urandom,
                   $urandom_range(3, 0), $urandom_range(3, 0), $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
